// File: rtl/login_pkg.sv
// Shared definitions for the login controller: state encoding, default
// credentials and the digit-extraction helper.
package login_pkg;

  localparam int DIGIT_W     = 4;
  localparam int CODE_DIGITS = 4;
  localparam int CODE_W      = DIGIT_W * CODE_DIGITS;

  localparam logic [CODE_W-1:0] DEF_ID_CODE  = 16'h1234;
  localparam logic [CODE_W-1:0] DEF_PWD_CODE = 16'h5678;

  typedef enum logic [2:0] {
    ENTER_ID  = 3'd0,
    ENTER_PWD = 3'd1,
    GRANTED   = 3'd2,
    DENY      = 3'd3,
    LOCKOUT   = 3'd4
  } state_t;

  // Position 0 is the most significant digit, i.e. the first one entered.
  function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_W-1:0] code,
                                                   input logic [1:0]        pos);
    logic [DIGIT_W-1:0] d;
    unique case (pos)
      2'd0:    d = code[4*DIGIT_W-1 -: DIGIT_W];
      2'd1:    d = code[3*DIGIT_W-1 -: DIGIT_W];
      2'd2:    d = code[2*DIGIT_W-1 -: DIGIT_W];
      default: d = code[1*DIGIT_W-1 -: DIGIT_W];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/login_lock_timer.sv
// Lockout interval timer: counts 0..LOCK_CYCLES-1 after start and flags the
// final cycle of the interval with a one-cycle done pulse.
module login_lock_timer #(
  parameter logic [31:0] LOCK_CYCLES = 32'd250000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  output logic done
);

  logic [31:0] count;
  logic        running;

  assign done = running && (count == LOCK_CYCLES - 32'd1);

  // NOTE: clocked state is written with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      count   <= '0;
      running <= 1'b1;
    end else if (done) begin
      count   <= '0;
      running <= 1'b0;
    end else if (running) begin
      count   <= count + 32'd1;
    end
  end

endmodule

// File: rtl/login_ctrl.sv
// Login-mode credential sequencer: 4-digit ID then 4-digit password, with
// failure counting and a timed lockout after MAX_FAIL consecutive denials.
module login_ctrl
  import login_pkg::*;
#(
  parameter logic [CODE_W-1:0] ID_CODE     = DEF_ID_CODE,
  parameter logic [CODE_W-1:0] PWD_CODE    = DEF_PWD_CODE,
  parameter int                MAX_FAIL    = 3,
  parameter logic [31:0]       LOCK_CYCLES = 32'd250000000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load_pulse,
  input  logic               logout_pulse,
  input  logic [DIGIT_W-1:0] digit_in,
  output logic               logged_in,
  output logic               fail_pulse,
  output logic               locked,
  output logic               pwd_phase,
  output logic [2:0]         digit_cnt
);

  localparam logic [2:0] FAIL_LIMIT = 3'(MAX_FAIL);

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [2:0]         fail_q, fail_d;
  logic               timer_start, timer_done;
  logic [DIGIT_W-1:0] expected;
  logic               match;

  assign expected = cnt_q[2] ? code_digit(PWD_CODE, cnt_q[1:0])
                             : code_digit(ID_CODE,  cnt_q[1:0]);
  assign match    = (digit_in == expected);

  login_lock_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_lock_timer (
    .CLK   (CLK),
    .RST   (RST),
    .start (timer_start),
    .done  (timer_done)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ENTER_ID;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  // NOTE: every signal assigned below gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    fail_d      = fail_q;
    timer_start = 1'b0;

    unique case (state_q)
      ENTER_ID, ENTER_PWD: begin
        if (logout_pulse) begin
          // Abort wins over a coincident load; the digit is dropped.
          state_d = ENTER_ID;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (load_pulse) begin
          if (cnt_q == 3'd7) begin
            if (!err_q && match) begin
              state_d = GRANTED;
              fail_d  = '0;
            end else begin
              state_d = DENY;
              fail_d  = fail_q + 3'd1;
            end
            cnt_d = '0;
            err_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 3'd1;
            err_d = err_q | ~match;
            if (cnt_q == 3'd3) state_d = ENTER_PWD;
          end
        end
      end

      GRANTED: begin
        if (logout_pulse) begin
          state_d = ENTER_ID;
          cnt_d   = '0;
        end
      end

      DENY: begin
        if (fail_q == FAIL_LIMIT) begin
          state_d     = LOCKOUT;
          timer_start = 1'b1;
        end else begin
          state_d = ENTER_ID;
        end
      end

      LOCKOUT: begin
        if (timer_done) begin
          state_d = ENTER_ID;
          fail_d  = '0;
        end
      end

      default: state_d = ENTER_ID;
    endcase
  end

  assign logged_in  = (state_q == GRANTED);
  assign fail_pulse = (state_q == DENY);
  assign locked     = (state_q == LOCKOUT);
  assign pwd_phase  = (state_q == ENTER_PWD);
  assign digit_cnt  = cnt_q;

endmodule

// File: tb/tb_login_ctrl.sv
// Directed self-checking bench for login_ctrl with a shortened lockout.
module tb_login_ctrl;

  localparam logic [31:0] LOCK = 32'd10;

  logic       CLK;
  logic       RST;
  logic       load_pulse;
  logic       logout_pulse;
  logic [3:0] digit_in;
  logic       logged_in;
  logic       fail_pulse;
  logic       locked;
  logic       pwd_phase;
  logic [2:0] digit_cnt;

  int checks   = 0;
  int failures = 0;

  login_ctrl #(
    .ID_CODE     (16'h1234),
    .PWD_CODE    (16'h5678),
    .MAX_FAIL    (3),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .load_pulse   (load_pulse),
    .logout_pulse (logout_pulse),
    .digit_in     (digit_in),
    .logged_in    (logged_in),
    .fail_pulse   (fail_pulse),
    .locked       (locked),
    .pwd_phase    (pwd_phase),
    .digit_cnt    (digit_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then sample 1 time unit later.
  task automatic step(input logic ld, input logic lo, input logic [3:0] d);
    load_pulse   = ld;
    logout_pulse = lo;
    digit_in     = d;
    @(posedge CLK);
    #1;
    load_pulse   = 1'b0;
    logout_pulse = 1'b0;
  endtask

  task automatic load(input logic [3:0] d);
    step(1'b1, 1'b0, d);
  endtask

  // Enters eight digits, first digit in the top nibble.
  task automatic attempt(input logic [31:0] digits);
    for (int i = 0; i < 8; i++) load(digits[31-4*i -: 4]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".logged_in"},  logged_in,  0);
    check({tag, ".fail_pulse"}, fail_pulse, 0);
    check({tag, ".locked"},     locked,     0);
    check({tag, ".pwd_phase"},  pwd_phase,  0);
    check({tag, ".digit_cnt"},  digit_cnt,  0);
  endtask

  // Wrong attempt, then confirm the DENY pulse and whether lockout follows.
  task automatic fail_once(input string tag, input logic expect_lock);
    attempt(32'h0000_0000);
    check({tag, ".fail"}, fail_pulse, 1);
    check({tag, ".granted"}, logged_in, 0);
    step(1'b0, 1'b0, 4'd0);
    check({tag, ".fail_gone"}, fail_pulse, 0);
    check({tag, ".lock"}, locked, expect_lock);
  endtask

  initial begin
    RST = 1'b0; load_pulse = 1'b0; logout_pulse = 1'b0; digit_in = 4'd0;
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    check_idle("reset");
    RST = 1'b1;

    // Correct login: count 1..7 then 0, password phase on digits 5..8.
    for (int i = 0; i < 8; i++) begin
      load(4'(i + 1));
      check($sformatf("ok.cnt%0d", i), digit_cnt, (i < 7) ? i + 1 : 0);
      check($sformatf("ok.pwd%0d", i), pwd_phase, (i >= 3 && i < 7) ? 1 : 0);
      check($sformatf("ok.fail%0d", i), fail_pulse, 0);
    end
    check("ok.logged_in", logged_in, 1);

    // GRANTED ignores loads; logout returns to ENTER_ID.
    load(4'd1);
    check("grant.ignore_load", logged_in, 1);
    check("grant.cnt", digit_cnt, 0);
    step(1'b0, 1'b1, 4'd0);
    check_idle("logout");

    // Wrong ID, correct password: still moves to the password phase.
    load(4'd1); load(4'd2); load(4'd9);
    check("badid.pwd_before", pwd_phase, 0);
    load(4'd4);
    check("badid.pwd_after", pwd_phase, 1);
    load(4'd5); load(4'd6); load(4'd7); load(4'd8);
    check("badid.fail", fail_pulse, 1);
    check("badid.granted", logged_in, 0);
    step(1'b0, 1'b0, 4'd0);
    check("badid.fail_one_cycle", fail_pulse, 0);
    check("badid.not_locked", locked, 0);
    check("badid.cnt", digit_cnt, 0);

    // Abort after three digits; fail count stays at 1.
    load(4'd1); load(4'd2); load(4'd3);
    check("abort.cnt3", digit_cnt, 3);
    step(1'b0, 1'b1, 4'd0);
    check("abort.cnt", digit_cnt, 0);
    check("abort.no_fail", fail_pulse, 0);

    // Coincident load and logout: logout wins, digit discarded.
    load(4'd1);
    step(1'b1, 1'b1, 4'd2);
    check("simul.cnt", digit_cnt, 0);
    load(4'd1);
    check("simul.fresh_cnt", digit_cnt, 1);
    step(1'b0, 1'b1, 4'd0);

    // Second failure: last digit out of BCD range.
    attempt(32'h1234_567F);
    check("hexdig.fail", fail_pulse, 1);
    step(1'b0, 1'b0, 4'd0);
    check("hexdig.not_locked", locked, 0);

    // Third failure locks for exactly LOCK cycles, loads ignored.
    fail_once("third", 1'b1);
    for (int j = 1; j < int'(LOCK); j++) begin
      load(4'd1);
      check($sformatf("lock.held%0d", j), locked, 1);
      check($sformatf("lock.cnt%0d", j), digit_cnt, 0);
    end
    load(4'd1);
    check("lock.released", locked, 0);
    check("lock.cnt_after", digit_cnt, 0);

    attempt(32'h1234_5678);
    check("relogin.logged_in", logged_in, 1);
    step(1'b0, 1'b1, 4'd0);
    check("relogin.logout", logged_in, 0);

    // Reset mid-attempt with two failures already counted.
    fail_once("pre1", 1'b0);
    fail_once("pre2", 1'b0);
    for (int i = 0; i < 6; i++) load(4'(i + 1));
    check("midrst.cnt6", digit_cnt, 6);
    RST = 1'b0;
    step(1'b0, 1'b0, 4'd0);
    check_idle("midrst");
    RST = 1'b1;
    fail_once("fresh1", 1'b0);
    fail_once("fresh2", 1'b0);
    fail_once("fresh3", 1'b1);

    // Reset during lockout clears it and the failure count.
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    check("lockrst.still_locked", locked, 1);
    RST = 1'b0;
    step(1'b0, 1'b0, 4'd0);
    check_idle("lockrst");
    RST = 1'b1;
    fail_once("postlock1", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/login_ctrl.md
Name: login_ctrl

Overview:
- Consumes the one-cycle button pulses produced by the button edge-shaper stage, together with a 4-bit digit from the board switches.
- Runs the Login-mode credential sequence: 4-digit user ID, then 4-digit password.
- Asserts logged_in to hand control to Game mode; enforces a lockout after repeated failures.
- Sits between the button shaper and the game/mode controller.

Parameters:
- ID_CODE, 16'h1234, expected ID; 4 BCD digits, most significant digit entered first.
- PWD_CODE, 16'h5678, expected password; 4 BCD digits, most significant digit entered first.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..7).
- LOCK_CYCLES, 32'd250000000, lockout duration in CLK cycles (5 s at 50 MHz).

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-low reset
- load_pulse  in  1  one-cycle digit-accept pulse from the button shaper
- logout_pulse  in  1  one-cycle abort/logout pulse from a second button shaper
- digit_in  in  4  current switch digit, sampled only when load_pulse=1
- logged_in  out  1  high while in GRANTED
- fail_pulse  out  1  high for exactly one cycle per failed attempt
- locked  out  1  high while in LOCKOUT
- pwd_phase  out  1  high while password digits are being entered
- digit_cnt  out  3  digits accepted in the current attempt, 0..7

Behaviour:
- Reset (RST=0 at a clock edge): state=ENTER_ID; digit_cnt=0; err flag=0; fail_cnt=0; timer=0. All outputs are 0.
- States: ENTER_ID, ENTER_PWD, GRANTED, DENY, LOCKOUT. Outputs are registered, or decoded from registered state only.
- ENTER_ID / ENTER_PWD, on load_pulse:
  - Compare digit_in with digit[digit_cnt] of ID_CODE (digit_cnt 0..3) or PWD_CODE (4..7).
  - On mismatch, set err (sticky for the attempt).
  - Increment digit_cnt at the same edge.
  - digit_in values >9 simply mismatch.
- ID/password switch: on the edge accepting the 4th digit, move to ENTER_PWD regardless of err. The ID result is never revealed separately.
- Attempt completion, on the edge accepting the 8th digit (digit_cnt=7):
  - err=0 and digit matches: go to GRANTED, fail_cnt=0.
  - Otherwise: go to DENY, fail_cnt+1.
  - In both cases clear digit_cnt and err.
  - logged_in or fail_pulse is therefore high in the cycle after the 8th load_pulse (latency 1).
- DENY: lasts exactly one cycle with fail_pulse=1.
  - Next state is LOCKOUT if fail_cnt==MAX_FAIL, else ENTER_ID.
  - load_pulse and logout_pulse are ignored during DENY.
- LOCKOUT:
  - locked=1; timer counts 0..LOCK_CYCLES-1.
  - When the timer reaches LOCK_CYCLES-1: go to ENTER_ID, clear fail_cnt and timer.
  - All pulses are ignored during LOCKOUT, so it lasts exactly LOCK_CYCLES cycles.
- GRANTED: logged_in=1. load_pulse is ignored. logout_pulse goes to ENTER_ID with digit_cnt=0.
- logout_pulse in ENTER_ID/ENTER_PWD: aborts the attempt (digit_cnt=0, err=0, state ENTER_ID). fail_cnt is unchanged and no fail_pulse is issued.
- Simultaneous load_pulse and logout_pulse: logout wins and the digit is discarded.
- pwd_phase = (state==ENTER_PWD).
- RST=0 overrides everything, including mid-attempt and mid-lockout.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package login_pkg:
  - state encoding constants (3-bit: ENTER_ID=0, ENTER_PWD=1, GRANTED=2, DENY=3, LOCKOUT=4);
  - default ID_CODE/PWD_CODE;
  - DIGIT_W=4, CODE_DIGITS=4.
- Sub-module login_lock_timer:
  - 32-bit down/up counter with start and done.
  - done is a one-cycle pulse on the final LOCKOUT cycle.
  - Instantiated once; start asserted on DENY->LOCKOUT.

Test Plan:
- Correct login: load 1,2,3,4,5,6,7,8 → digit_cnt steps 1..7 then 0; pwd_phase rises after the 4th load; logged_in=1 the cycle after the 8th load, fail_pulse never asserted.
- Wrong ID, correct password: load 1,2,9,4,5,6,7,8 → still enters ENTER_PWD after the 4th digit; after the 8th, a single-cycle fail_pulse; returns to ENTER_ID; logged_in stays 0.
- Lockout (LOCK_CYCLES=10): three wrong 8-digit attempts → three fail_pulses, then locked=1 for exactly 10 cycles.
  - Loads during lockout have no effect on digit_cnt.
  - A subsequent correct sequence grants login.
- Abort and simultaneity: 3 digits, then logout_pulse → digit_cnt=0, fail_cnt unchanged. In another attempt, load_pulse and logout_pulse in the same cycle → digit_cnt=0, digit discarded.
- Logout from GRANTED: logged_in=1; load_pulse ignored; logout_pulse → logged_in=0 next cycle, state ENTER_ID.
- Reset mid-operation: assert RST=0 at digit_cnt=6 and separately during LOCKOUT → all outputs 0 the next cycle; fail_cnt cleared, so three fresh failures are needed to lock again.
